// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Serial program loader that sits in front of the instruction memory of a
// 16-bit single-cycle core. A byte stream arrives over a valid/ready
// handshake in this frame layout:
//   LEN_HI LEN_LO {HI LO} x length CHK
// Each HI/LO pair becomes one big-endian instruction word, and that word is
// written to memory at byte address 2*index. CHK is the XOR of every byte
// before it. The core is held in reset until a load completes cleanly.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         one-cycle pulse that begins a load (honoured in IDLE/DONE/ERROR)
//   rx_data       incoming stream byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte this cycle (decoded from state)
//   imem_we       instruction memory write strobe, one cycle per word
//   imem_addr     byte address of the word being written
//   imem_wdata    instruction word {high byte, low byte}
//   cpu_reset     core reset, low only after a successful load
//   busy          a load is in progress
//   done          last load succeeded
//   error         last load failed (bad length or bad checksum)
//   words_loaded  words written in the current or last load
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    // 17 bits so a length of exactly 0x10000 words could never alias to 0.
    localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [15:0]         length_q, length_d;
    logic [15:0]         index_q, index_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          hi_q, hi_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [15:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [15:0]         words_loaded_q, words_loaded_d;

    logic                accept;
    logic [15:0]         length_full;

    always_comb begin
        rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                   (state_q == DATA_HI) || (state_q == DATA_LO) ||
                   (state_q == CHK);
    end

    assign accept      = rx_valid && rx_ready;
    assign length_full = {length_q[15:8], rx_data};

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through the block leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        length_d       = length_q;
        index_d        = index_q;
        chk_d          = chk_q;
        hi_d           = hi_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_reset_d    = cpu_reset_q;
        busy_d         = busy_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d        = LEN_HI;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = '0;
                    index_d        = '0;
                    chk_d          = '0;
                    busy_d         = 1'b1;
                    cpu_reset_d    = 1'b1;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    length_d = {rx_data, length_q[7:0]};
                    chk_d    = chk_q ^ rx_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    length_d = length_full;
                    chk_d    = chk_q ^ rx_data;
                    if ((length_full == '0) || ({1'b0, length_full} > MAX_WORDS_L)) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                // The strobe is registered, so it lands in the WRITE cycle
                // together with the address and data captured here.
                if (accept) begin
                    chk_d        = chk_q ^ rx_data;
                    imem_we_d    = 1'b1;
                    imem_wdata_d = {hi_q, rx_data};
                    imem_addr_d  = ADDR_W'({index_q, 1'b0});
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                index_d        = index_q + 16'd1;
                words_loaded_d = words_loaded_q + 16'd1;
                state_d        = (index_q + 16'd1 == length_q) ? CHK : DATA_HI;
            end
            CHK: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (rx_data == chk_q) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q        <= IDLE;
            length_q       <= '0;
            index_q        <= '0;
            chk_q          <= '0;
            hi_q           <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            length_q       <= length_d;
            index_q        <= index_d;
            chk_q          <= chk_d;
            hi_q           <= hi_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Serial program loader upstream of the 16-bit single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes the words into instruction memory through its write port, then checks an XOR checksum.
- Holds the core in reset until a load completes cleanly.

Parameters:
- MAX_WORDS, 256: instruction memory depth in 16-bit words; the largest accepted length field.
- ADDR_W, 16: width of imem_addr, a byte address, always even.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse to begin a load; honoured only in IDLE, DONE or ERROR.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the word being written (2*index).
- imem_wdata  out  16  instruction word, {high byte, low byte}.
- cpu_reset  out  1  reset to the core; high except in DONE.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.
- words_loaded  out  16  number of words written in the current or last load.

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-high.
  - Ports are named clk and reset.
  - All outputs are registered except rx_ready, which decodes from the state.
- Reset values:
  - state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, busy=0, done=0, error=0, words_loaded=0.
  - Internal length=0, index=0, chk=0.
- Byte transfer: a byte is accepted only in a cycle where rx_valid and rx_ready are both 1. rx_valid without rx_ready is held off and not consumed.
- rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- States and transitions:
  - IDLE: on start go to LEN_HI; clear done, error, words_loaded, index and chk; set busy=1.
  - LEN_HI: on accept, length[15:8]=byte, chk^=byte, go to LEN_LO.
  - LEN_LO: on accept, length[7:0]=byte, chk^=byte. If the full length is 0 or greater than MAX_WORDS, go to ERROR; otherwise go to DATA_HI.
  - DATA_HI: on accept, latch the high byte, chk^=byte, go to DATA_LO.
  - DATA_LO: on accept, chk^=byte, load imem_wdata={hi,byte} and imem_addr=index<<1, go to WRITE.
  - WRITE:
    - Lasts exactly one cycle: imem_we=1 and rx_ready=0.
    - index and words_loaded increment.
    - If the incremented index equals length, go to CHK; else go to DATA_HI.
  - CHK: on accept, go to DONE if byte==chk, else go to ERROR.
  - DONE: done=1, busy=0, cpu_reset=0. On start, go to LEN_HI as from IDLE; cpu_reset goes back to 1 on the same edge.
  - ERROR: error=1, busy=0, cpu_reset=1. On start, retry as from IDLE.
- Latency and throughput:
  - imem_we asserts in the cycle after the low byte is accepted.
  - Minimum rate is 3 cycles per word.
- Checksum: XOR over both length bytes and all data bytes; it excludes the checksum byte itself.
- start handling: start is ignored in LEN_HI..CHK. If start coincides with a byte in IDLE, the byte is not consumed.
- Reset mid-load: at the next edge all outputs and state return to their reset values. Words already written remain in memory. A new start performs a full reload.
- Bounds: length==MAX_WORDS is legal. The last address written is 2*(MAX_WORDS-1); imem_addr never wraps.

Test Plan:
- Good load: start, then bytes 00 02 12 34 AB CD 42 with rx_valid held high -> imem_we pulses twice, writing (0x0000,0x1234) and (0x0002,0xABCD); done=1, cpu_reset=0, words_loaded=2, error=0.
- Bad checksum: same stream with last byte 0x43 -> both writes occur, then error=1, done=0, cpu_reset stays 1, words_loaded=2.
- Bad length: stream 00 00 -> ERROR after the second byte with no imem_we; stream 01 01 (257 > 256) -> ERROR; a following start plus the good stream -> done=1.
- Backpressure: rx_valid toggling randomly, and rx_valid=1 during WRITE -> the byte is not consumed until the next DATA_HI cycle; the written words are identical to the good-load case.
- Reset mid-load: assert reset for one cycle after the first write -> next cycle busy=0, cpu_reset=1, words_loaded=0, imem_addr=0; start with the good stream -> done=1.
- start while busy: pulse start during DATA_HI -> no state change; the load completes normally. start in DONE -> cpu_reset=1 on the next cycle and busy=1.
